// File: rtl/hamming_decoder_if.sv
// Bus bundle for hamming_decoder: req/done handshake plus the data-memory port.
// The decoder takes the master side; the core/memory side takes the slave side.
interface hamming_decoder_if #(
  parameter int AW = 8
);
  logic          req;
  logic          done;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic [7:0]    single_cnt;
  logic [7:0]    double_cnt;

  modport master (
    input  req, mem_rdata,
    output done, busy, mem_addr, mem_we, mem_wdata, single_cnt, double_cnt
  );

  modport slave (
    output req, mem_rdata,
    input  done, busy, mem_addr, mem_we, mem_wdata, single_cnt, double_cnt
  );
endinterface

// File: rtl/hamming_decoder.sv
// SECDED Hamming decoder engine: walks NUM_WORDS codewords in data memory and writes back {flags, 11-bit message}.
// Optional error statistics counters are built when HAMMING_DEC_STATS_EN is defined.
module hamming_decoder #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int AW        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  hamming_decoder_if.master bus
);

  localparam int IW = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;
  localparam logic [AW-1:0] SRC      = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST      = AW'(DST_BASE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_cwLo;
  logic [7:0]    r_cwHi;
  logic          r_done;

  logic [15:0]   w_cw;
  logic [3:0]    w_syn;
  logic          w_par;
  logic [15:0]   w_fix;
  logic [1:0]    w_flag;
  logic [10:0]   w_data;
  logic [7:0]    w_outLo;
  logic [7:0]    w_outHi;
  logic [AW-1:0] w_off;

  // Syndrome bit j covers every position 1..15 whose index has bit j set.
  always_comb begin
    w_cw  = {r_cwHi, r_cwLo};
    w_syn = '0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 1; k < 16; k++) begin
        if (k[j]) w_syn[j] = w_syn[j] ^ w_cw[k];
      end
    end
    w_par = ^w_cw;
    w_fix = w_cw;
    if ((w_syn != 4'd0) && w_par) w_fix[w_syn] = ~w_cw[w_syn];
    case ({(w_syn != 4'd0), w_par})
      2'b00:   w_flag = 2'b00;
      2'b10:   w_flag = 2'b10;
      default: w_flag = 2'b01;
    endcase
    w_data  = {w_fix[15:9], w_fix[7:5], w_fix[3]};
    w_outLo = w_data[7:0];
    w_outHi = {w_flag, 3'b000, w_data[10:8]};
  end

  assign w_off = AW'({r_idx, 1'b0});

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (r_state)
      RD_LO: bus.mem_addr = SRC + w_off;
      RD_HI: bus.mem_addr = SRC + w_off + AW'(1);
      WR_LO: begin
        bus.mem_addr  = DST + w_off;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = w_outLo;
      end
      WR_HI: begin
        bus.mem_addr  = DST + w_off + AW'(1);
        bus.mem_we    = 1'b1;
        bus.mem_wdata = w_outHi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cwLo  <= '0;
      r_cwHi  <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_state <= RD_LO;
            r_idx   <= '0;
            r_done  <= 1'b0;
          end
        end
        RD_LO: begin
          r_cwLo  <= bus.mem_rdata;
          r_state <= RD_HI;
        end
        RD_HI: begin
          r_cwHi  <= bus.mem_rdata;
          r_state <= WR_LO;
        end
        WR_LO: r_state <= WR_HI;
        WR_HI: begin
          r_idx <= r_idx + IW'(1);
          if (r_idx == LAST_IDX) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= RD_LO;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.done = r_done;
  assign bus.busy = (r_state != IDLE);

`ifdef HAMMING_DEC_STATS_EN
  logic [7:0] r_singleCnt;
  logic [7:0] r_doubleCnt;

  // Counts are taken once per word as it leaves WR_HI, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_singleCnt <= '0;
      r_doubleCnt <= '0;
    end else if ((r_state == IDLE) && bus.req) begin
      r_singleCnt <= '0;
      r_doubleCnt <= '0;
    end else if (r_state == WR_HI) begin
      if ((w_flag == 2'b01) && (r_singleCnt != 8'hFF)) r_singleCnt <= r_singleCnt + 8'd1;
      if ((w_flag == 2'b10) && (r_doubleCnt != 8'hFF)) r_doubleCnt <= r_doubleCnt + 8'd1;
    end
  end

  assign bus.single_cnt = r_singleCnt;
  assign bus.double_cnt = r_doubleCnt;
`else
  assign bus.single_cnt = 8'd0;
  assign bus.double_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder: table vectors, random codewords vs a position-based decode model,
// plus mid-run reset and ignored-req sequences.
module tb_hamming_decoder;
  localparam int NW   = 15;
  localparam int SRCB = 30;
  localparam int DSTB = 0;

  typedef struct {
    logic [7:0] lsw;
    logic [7:0] msw;
    logic [7:0] expLsw;
    logic [7:0] expMsw;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0]  mem [0:255];
  logic [15:0] src [NW];
  vec_t        vecs [4];
  int          assertCount = 0;
  int          failCount   = 0;
  int          doneEdge;

  always #5 clk = ~clk;

  hamming_decoder_if #(.AW(8)) busIf();

  hamming_decoder #(
    .NUM_WORDS(NW),
    .SRC_BASE (SRCB),
    .DST_BASE (DSTB),
    .AW       (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busIf)
  );

  assign busIf.mem_rdata = mem[busIf.mem_addr];

  always @(posedge clk) begin
    if (busIf.mem_we) mem[busIf.mem_addr] <= busIf.mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode: syndrome is the XOR of the indices of all set bits, data bits are the non-power-of-two positions.
  function automatic logic [15:0] modelDecode(input logic [15:0] cw, output logic [1:0] flag);
    int          syn  = 0;
    int          ones = 0;
    int          n    = 0;
    logic [15:0] fixed;
    logic [10:0] data;
    for (int k = 0; k < 16; k++) begin
      if (cw[k]) begin
        ones++;
        syn = syn ^ k;
      end
    end
    fixed = cw;
    data  = '0;
    if ((syn != 0) && (ones % 2 == 1)) fixed[syn] = ~fixed[syn];
    if (ones % 2 == 1)  flag = 2'b01;
    else if (syn == 0)  flag = 2'b00;
    else                flag = 2'b10;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        data[n] = fixed[k];
        n++;
      end
    end
    return {flag, 3'b000, data};
  endfunction

  task automatic loadSource(input bit useTable);
    for (int i = 0; i < NW; i++) begin
      if (useTable && i < 4) src[i] = {vecs[i].msw, vecs[i].lsw};
      else                   src[i] = 16'($urandom_range(0, 65535));
      mem[SRCB + 2*i]     <= src[i][7:0];
      mem[SRCB + 2*i + 1] <= src[i][15:8];
      mem[DSTB + 2*i]     <= 8'h00;
      mem[DSTB + 2*i + 1] <= 8'h00;
    end
    @(negedge clk);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "Done"},  16'(busIf.done), 16'd0);
    checkOutput({tag, "Busy"},  16'(busIf.busy), 16'd0);
    checkOutput({tag, "We"},    16'(busIf.mem_we), 16'd0);
    checkOutput({tag, "Addr"},  16'(busIf.mem_addr), 16'd0);
    checkOutput({tag, "Wdata"}, 16'(busIf.mem_wdata), 16'd0);
    checkOutput({tag, "Single"}, 16'(busIf.single_cnt), 16'd0);
    checkOutput({tag, "Double"}, 16'(busIf.double_cnt), 16'd0);
  endtask

  // Edge 0 is the posedge that samples req; doneEdge is the first edge after which done reads high.
  task automatic applyStimulus(input int midReqCycle, input int resetCycle, output int edgeSeen);
    @(negedge clk);
    busIf.req = 1'b1;
    @(posedge clk);
    #1;
    busIf.req = 1'b0;
    checkOutput("startBusy", 16'(busIf.busy), 16'd1);
    checkOutput("startDone", 16'(busIf.done), 16'd0);
    edgeSeen = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (busIf.done) begin
        edgeSeen = c;
        break;
      end
      busIf.req = (c == midReqCycle);
      if (c == resetCycle) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleZero("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        edgeSeen = -2;
        break;
      end
    end
    busIf.req = 1'b0;
  endtask

  task automatic checkRun(input bit useTable);
    logic [15:0] exp;
    logic [1:0]  flag;
    int          expSingle = 0;
    int          expDouble = 0;
    for (int i = 0; i < NW; i++) begin
      exp = modelDecode(src[i], flag);
      if (flag == 2'b01) expSingle++;
      if (flag == 2'b10) expDouble++;
      checkOutput($sformatf("w%0dLo", i), 16'(mem[DSTB + 2*i]), 16'(exp[7:0]));
      checkOutput($sformatf("w%0dHi", i), 16'(mem[DSTB + 2*i + 1]), 16'(exp[15:8]));
      if (useTable && i < 4) begin
        checkOutput($sformatf("tbl%0dLo", i), 16'(mem[DSTB + 2*i]), 16'(vecs[i].expLsw));
        checkOutput($sformatf("tbl%0dHi", i), 16'(mem[DSTB + 2*i + 1]), 16'(vecs[i].expMsw));
      end
    end
`ifdef HAMMING_DEC_STATS_EN
    checkOutput("singleCnt", 16'(busIf.single_cnt), 16'(expSingle));
    checkOutput("doubleCnt", 16'(busIf.double_cnt), 16'(expDouble));
`else
    checkOutput("singleCnt", 16'(busIf.single_cnt), 16'd0);
    checkOutput("doubleCnt", 16'(busIf.double_cnt), 16'd0);
    if (expSingle + expDouble < 0) $display("[TB] unreachable");
`endif
  endtask

  initial begin
    vecs[0] = '{lsw: 8'h5A, msw: 8'hAA, expLsw: 8'h55, expMsw: 8'h05};
    vecs[1] = '{lsw: 8'h1A, msw: 8'hAA, expLsw: 8'h55, expMsw: 8'h45};
    vecs[2] = '{lsw: 8'h5B, msw: 8'hAA, expLsw: 8'h55, expMsw: 8'h45};
    vecs[3] = '{lsw: 8'h1A, msw: 8'hA8, expLsw: 8'h41, expMsw: 8'h85};

    busIf.req = 1'b0;
    rst_n     = 1'b1;
    #1;
    rst_n = 1'b0;
    #11;
    checkIdleZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] run A: table vectors plus random codewords");
    loadSource(1'b1);
    applyStimulus(0, 0, doneEdge);
    checkOutput("runADoneEdge", 16'(doneEdge), 16'd60);
    checkOutput("runABusy", 16'(busIf.busy), 16'd0);
    checkRun(1'b1);

    $display("[TB] run B: req pulse mid-run is ignored");
    loadSource(1'b0);
    applyStimulus(20, 0, doneEdge);
    checkOutput("runBDoneEdge", 16'(doneEdge), 16'd60);
    checkRun(1'b0);

    $display("[TB] run C: reset at cycle 10, then full restart");
    loadSource(1'b0);
    applyStimulus(0, 10, doneEdge);
    checkOutput("runCResetSeen", 16'(doneEdge), 16'hFFFE);
    applyStimulus(0, 0, doneEdge);
    checkOutput("runCDoneEdge", 16'(doneEdge), 16'd60);
    checkRun(1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("doneSticky", 16'(busIf.done), 16'd1);

    $display("[TB] run D: next req clears done");
    loadSource(1'b0);
    applyStimulus(0, 0, doneEdge);
    checkOutput("runDDoneEdge", 16'(doneEdge), 16'd60);
    checkRun(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/hamming_decoder.md
# hamming_decoder

Memory-side SECDED Hamming decoder engine, the receive-side counterpart to the program-1 encoder. On a `req` pulse it walks `NUM_WORDS` 16-bit codewords stored as byte pairs in data memory, corrects single-bit errors, flags double-bit errors, and writes the 11-bit messages plus a 2-bit status back to data memory, then raises `done`. It sits beside the core on the data-memory port and uses the same `req`/`done` handshake as `top_level`.

## Interface
- `NUM_WORDS`, 15: codewords per request.
- `SRC_BASE`, 30: byte address of the first input codeword's LSW.
- `DST_BASE`, 0: byte address of the first output word's LSW.
- `AW`, 8: data-memory address width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  start pulse; sampled only in IDLE.
- `done`  out  1  sticky completion flag.
- `busy`  out  1  high in any non-IDLE state.
- `mem_addr`  out  AW  data-memory byte address.
- `mem_we`  out  1  write enable; memory writes on the rising edge.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  combinational read data for `mem_addr`.
- `single_cnt`  out  8  corrected-word count.
- `double_cnt`  out  8  double-error count.

## Operation
- Codeword bit k (0..15): MSW holds bits 15..8 and LSW holds bits 7..0. Positions 0, 1, 2, 4 and 8 are p0, p1, p2, p4 and p8. Data bits b1..b11 occupy positions 3, 5, 6, 7, 9..15 in ascending order.
- Syndrome S = {s8,s4,s2,s1}, where sN is the XOR of bits whose position index has bit N set (positions 1..15). P is the XOR of all 16 bits.
- Decode cases:
  - S=0, P=0: no error, F=00.
  - S≠0, P=1: flip bit S, F=01.
  - S=0, P=1: p0 error, data unchanged, F=01.
  - S≠0, P=0: double error, data passed uncorrected, F=10.
- Output layout: MSW = {F1, F0, 3'b000, b11, b10, b9}; LSW = {b8..b1}.
- Word i reads `SRC_BASE+2i` (LSW) and `SRC_BASE+2i+1` (MSW). It writes `DST_BASE+2i` and `DST_BASE+2i+1`.
- FSM: IDLE → RD_LO → RD_HI → WR_LO → WR_HI. After WR_HI, go to RD_LO if `idx < NUM_WORDS-1`, otherwise to IDLE. Each state lasts one cycle.
  - RD_LO captures `mem_rdata` into `cw_lo`.
  - RD_HI captures `mem_rdata` into `cw_hi`.
  - Decode is combinational from `cw_hi`/`cw_lo`.
  - WR_LO and WR_HI assert `mem_we` with the decoded bytes.
- `idx` is a word counter wide enough for `NUM_WORDS-1`. It is cleared on req acceptance and incremented on leaving WR_HI.
- `done` sets on the edge that leaves the final WR_HI. It clears on the edge that accepts the next `req`.
- `req` while busy is ignored, with no restart and no queuing.
- `mem_addr`, `mem_we` and `mem_wdata` are combinational from state. In IDLE they are 0.

## Timing
- Reset (asynchronous, any state including mid-run):
  - State goes to IDLE.
  - `done`=0, `busy`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `idx`, `cw_lo`, `cw_hi`, `single_cnt` and `double_cnt` go to 0.
  - Partially written output stays in memory.
- Latency: take the edge that samples `req`=1 as edge 0. Word i occupies cycles 4i+1..4i+4. `done` rises at edge 4·NUM_WORDS, which is edge 60 for the default.
- Throughput: 4 cycles per word. No gaps between words.
- Read data must be valid in the same cycle as `mem_addr`.
- Source and destination regions may overlap. Each word is fully read before it is written.

## Configuration
- `HAMMING_DEC_STATS_EN` defined:
  - `single_cnt` increments on each F=01 word.
  - `double_cnt` increments on each F=10 word.
  - Both saturate at 255 and clear on req acceptance and on reset.
- `HAMMING_DEC_STATS_EN` undefined:
  - No counter registers are built.
  - Both ports are tied to 0.

## Test plan
- Clean codeword: MSW 0xAA, LSW 0x5A at addr 31/30 → addr 1/0 = 0x05/0x55, F=00, `done` at edge 60.
- Single-bit error in bit 6: LSW 0x1A, MSW 0xAA → 0x45/0x55.
- p0-only error: LSW 0x5B, MSW 0xAA → 0x45/0x55, data unchanged.
- Double-bit error in bits 6 and 9: LSW 0x1A, MSW 0xA8 → 0x85/0x41, uncorrected, F=10.
  - With `HAMMING_DEC_STATS_EN`: `double_cnt` = 1.
- Reset and restart: assert `rst_n`=0 at cycle 10 of a run → all outputs are 0 immediately. A new `req` then completes all 15 words, and `done` stays high until the following `req`.
- Ignored `req`: a `req` pulse mid-run → no restart, and `done` still rises at edge 60.
